// File: rtl/multicycle_control.sv
// Multi-cycle RV32I control sequencer: steps each instruction through
// fetch/decode/execute/memory/writeback with bounded memory handshakes.
module multicycle_control #(
    parameter bit ENABLE_M    = 1'b0,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        br_taken,
    input  logic        imem_ack,
    input  logic        dmem_ack,
    input  logic        muldiv_done,
    output logic        imem_req,
    output logic        ir_we,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic        alu_src,
    output logic [4:0]  alu_ctrl,
    output logic [2:0]  imm_sel,
    output logic        reg_write,
    output logic [1:0]  wb_sel,
    output logic        pc_we,
    output logic [1:0]  pc_sel,
    output logic        muldiv_start,
    output logic        trap,
    output logic [1:0]  trap_cause,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_MULDIV = 3'd5,
        S_TRAP   = 3'd6
    } state_t;

    typedef enum logic [3:0] {
        CL_ALU, CL_LOAD, CL_STORE, CL_BRANCH, CL_FENCE, CL_JAL, CL_JALR, CL_MULDIV
    } cls_t;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;

    localparam logic [4:0] ALU_ADD  = 5'd0;
    localparam logic [4:0] ALU_SUB  = 5'd1;
    localparam logic [4:0] ALU_AND  = 5'd2;
    localparam logic [4:0] ALU_OR   = 5'd3;
    localparam logic [4:0] ALU_XOR  = 5'd4;
    localparam logic [4:0] ALU_SLL  = 5'd5;
    localparam logic [4:0] ALU_SRL  = 5'd6;
    localparam logic [4:0] ALU_SRA  = 5'd7;
    localparam logic [4:0] ALU_SLT  = 5'd8;
    localparam logic [4:0] ALU_SLTU = 5'd9;

    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_U = 3'd3;
    localparam logic [2:0] IMM_J = 3'd4;

    localparam logic [1:0] CAUSE_ILLEGAL = 2'd0;
    localparam logic [1:0] CAUSE_IMEM    = 2'd1;
    localparam logic [1:0] CAUSE_DMEM    = 2'd2;

    localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [7:0]  tmo_cnt;
    logic [1:0]  cause_q, cause_d;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    cls_t        cls;
    logic        illegal;
    logic        dec_alu_src;
    logic [4:0]  dec_alu_ctrl;
    logic [2:0]  dec_imm_sel;
    logic        timeout_hit;
    logic        unused_instr_bits;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];
    assign unused_instr_bits = ^{instr[24:15], instr[11:7]};
    assign timeout_hit = (tmo_cnt == TMO_LAST);

    function automatic logic [4:0] alu_base(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        cls          = CL_ALU;
        illegal      = 1'b0;
        dec_alu_src  = 1'b0;
        dec_alu_ctrl = ALU_ADD;
        dec_imm_sel  = IMM_I;
        case (opcode)
            OP_LUI, OP_AUIPC: begin
                dec_alu_src = 1'b1;
                dec_imm_sel = IMM_U;
            end
            OP_JAL: begin
                cls         = CL_JAL;
                dec_alu_src = 1'b1;
                dec_imm_sel = IMM_J;
            end
            OP_JALR: begin
                cls         = CL_JALR;
                dec_alu_src = 1'b1;
                illegal     = (funct3 != 3'b000);
            end
            OP_BRANCH: begin
                cls         = CL_BRANCH;
                dec_imm_sel = IMM_B;
                case (funct3[2:1])
                    2'b00:   dec_alu_ctrl = ALU_SUB;
                    2'b10:   dec_alu_ctrl = ALU_SLT;
                    2'b11:   dec_alu_ctrl = ALU_SLTU;
                    default: illegal = 1'b1;
                endcase
            end
            OP_LOAD: begin
                cls         = CL_LOAD;
                dec_alu_src = 1'b1;
                illegal     = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
            end
            OP_STORE: begin
                cls         = CL_STORE;
                dec_alu_src = 1'b1;
                dec_imm_sel = IMM_S;
                illegal     = funct3[2] || (funct3[1:0] == 2'b11);
            end
            OP_IMM: begin
                dec_alu_src  = 1'b1;
                dec_alu_ctrl = alu_base(funct3, 1'b0);
                if (funct3 == 3'b001) begin
                    illegal = (funct7 != 7'b0000000);
                end else if (funct3 == 3'b101) begin
                    dec_alu_ctrl = alu_base(funct3, funct7[5]);
                    illegal      = (funct7 != 7'b0000000) && (funct7 != 7'b0100000);
                end
            end
            OP_REG: begin
                case (funct7)
                    7'b0000000: dec_alu_ctrl = alu_base(funct3, 1'b0);
                    7'b0100000: begin
                        dec_alu_ctrl = alu_base(funct3, 1'b1);
                        illegal      = (funct3 != 3'b000) && (funct3 != 3'b101);
                    end
                    7'b0000001: begin
                        cls          = CL_MULDIV;
                        dec_alu_ctrl = {2'b10, funct3};
                        illegal      = !ENABLE_M;
                    end
                    default: illegal = 1'b1;
                endcase
            end
            OP_FENCE: cls = CL_FENCE;
            default:  illegal = 1'b1;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        cause_d      = cause_q;
        imem_req     = 1'b0;
        ir_we        = 1'b0;
        dmem_req     = 1'b0;
        dmem_we      = 1'b0;
        alu_src      = 1'b0;
        alu_ctrl     = 5'd0;
        imm_sel      = 3'd0;
        reg_write    = 1'b0;
        wb_sel       = 2'd0;
        pc_we        = 1'b0;
        pc_sel       = 2'd0;
        muldiv_start = 1'b0;
        trap         = 1'b0;
        trap_cause   = 2'd0;
        state        = state_q;

        // Decoded ALU controls stay valid for the whole post-decode life of the instruction.
        if (state_q inside {S_EXEC, S_MEM, S_MULDIV, S_WB}) begin
            alu_src  = dec_alu_src;
            alu_ctrl = dec_alu_ctrl;
            imm_sel  = dec_imm_sel;
        end

        case (state_q)
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    ir_we   = 1'b1;
                    state_d = S_DECODE;
                end else if (timeout_hit) begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_IMEM;
                end
            end
            S_DECODE: begin
                if (illegal) begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_ILLEGAL;
                end else if (cls == CL_MULDIV) begin
                    muldiv_start = 1'b1;
                    state_d      = S_MULDIV;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                case (cls)
                    CL_BRANCH: begin
                        pc_we   = 1'b1;
                        pc_sel  = br_taken ? 2'd1 : 2'd0;
                        state_d = S_FETCH;
                    end
                    CL_FENCE: begin
                        pc_we   = 1'b1;
                        state_d = S_FETCH;
                    end
                    CL_LOAD, CL_STORE: state_d = S_MEM;
                    default:           state_d = S_WB;
                endcase
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = (cls == CL_STORE);
                if (dmem_ack) begin
                    if (cls == CL_STORE) begin
                        pc_we   = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (timeout_hit) begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_DMEM;
                end
            end
            S_MULDIV: begin
                if (muldiv_done) state_d = S_WB;
            end
            S_WB: begin
                reg_write = 1'b1;
                pc_we     = 1'b1;
                state_d   = S_FETCH;
                case (cls)
                    CL_LOAD:   wb_sel = 2'd1;
                    CL_JAL:    begin wb_sel = 2'd2; pc_sel = 2'd1; end
                    CL_JALR:   begin wb_sel = 2'd2; pc_sel = 2'd2; end
                    CL_MULDIV: wb_sel = 2'd3;
                    default:   wb_sel = 2'd0;
                endcase
            end
            S_TRAP: begin
                trap       = 1'b1;
                trap_cause = cause_q;
            end
            default: state_d = S_FETCH;
        endcase

        // Reset masks every strobe in the same cycle, before the state register catches up.
        if (rst) begin
            imem_req     = 1'b0;
            ir_we        = 1'b0;
            dmem_req     = 1'b0;
            dmem_we      = 1'b0;
            alu_src      = 1'b0;
            alu_ctrl     = 5'd0;
            imm_sel      = 3'd0;
            reg_write    = 1'b0;
            wb_sel       = 2'd0;
            pc_we        = 1'b0;
            pc_sel       = 2'd0;
            muldiv_start = 1'b0;
            trap         = 1'b0;
            trap_cause   = 2'd0;
            state        = 3'd0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
            cause_q <= CAUSE_ILLEGAL;
            tmo_cnt <= 8'd0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            if (state_d != state_q) begin
                tmo_cnt <= 8'd0;
            end else if (state_q == S_FETCH || state_q == S_MEM) begin
                tmo_cnt <= tmo_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: per-cycle expected outputs are
// queued when an instruction is launched and compared as the DUT steps.
module tb_multicycle_control;

    typedef struct packed {
        logic [2:0] state;
        logic       imem_req;
        logic       ir_we;
        logic       dmem_req;
        logic       dmem_we;
        logic       alu_src;
        logic [4:0] alu_ctrl;
        logic [2:0] imm_sel;
        logic       reg_write;
        logic [1:0] wb_sel;
        logic       pc_we;
        logic [1:0] pc_sel;
        logic       muldiv_start;
        logic       trap;
        logic [1:0] trap_cause;
    } out_t;

    typedef enum int { C_ALU, C_LOAD, C_STORE, C_BR, C_FENCE, C_JAL, C_JALR, C_MD, C_ILL } cls_e;

    typedef struct {
        logic [31:0] instr;
        logic        br;
        cls_e        cls;
        logic        src;
        logic [4:0]  ctrl;
        logic [2:0]  imm;
        string       name;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] instr = 32'h0;
    logic        br_taken = 1'b0;
    logic        imem_ack = 1'b0;
    logic        dmem_ack = 1'b0;
    logic        muldiv_done = 1'b0;

    logic a_imem_req, a_ir_we, a_dmem_req, a_dmem_we, a_alu_src, a_reg_write, a_pc_we, a_muldiv_start, a_trap;
    logic [4:0] a_alu_ctrl;
    logic [2:0] a_imm_sel, a_state;
    logic [1:0] a_wb_sel, a_pc_sel, a_trap_cause;
    logic m_imem_req, m_ir_we, m_dmem_req, m_dmem_we, m_alu_src, m_reg_write, m_pc_we, m_muldiv_start, m_trap;
    logic [4:0] m_alu_ctrl;
    logic [2:0] m_imm_sel, m_state;
    logic [1:0] m_wb_sel, m_pc_sel, m_trap_cause;

    always #5 clk = ~clk;

    multicycle_control #(.ENABLE_M(1'b0), .MEM_TIMEOUT(4)) dut_a (
        .clk(clk), .rst(rst), .instr(instr), .br_taken(br_taken),
        .imem_ack(imem_ack), .dmem_ack(dmem_ack), .muldiv_done(muldiv_done),
        .imem_req(a_imem_req), .ir_we(a_ir_we), .dmem_req(a_dmem_req), .dmem_we(a_dmem_we),
        .alu_src(a_alu_src), .alu_ctrl(a_alu_ctrl), .imm_sel(a_imm_sel), .reg_write(a_reg_write),
        .wb_sel(a_wb_sel), .pc_we(a_pc_we), .pc_sel(a_pc_sel), .muldiv_start(a_muldiv_start),
        .trap(a_trap), .trap_cause(a_trap_cause), .state(a_state)
    );

    multicycle_control #(.ENABLE_M(1'b1), .MEM_TIMEOUT(16)) dut_m (
        .clk(clk), .rst(rst), .instr(instr), .br_taken(br_taken),
        .imem_ack(imem_ack), .dmem_ack(dmem_ack), .muldiv_done(muldiv_done),
        .imem_req(m_imem_req), .ir_we(m_ir_we), .dmem_req(m_dmem_req), .dmem_we(m_dmem_we),
        .alu_src(m_alu_src), .alu_ctrl(m_alu_ctrl), .imm_sel(m_imm_sel), .reg_write(m_reg_write),
        .wb_sel(m_wb_sel), .pc_we(m_pc_we), .pc_sel(m_pc_sel), .muldiv_start(m_muldiv_start),
        .trap(m_trap), .trap_cause(m_trap_cause), .state(m_state)
    );

    out_t obs_a, obs_m;
    assign obs_a = {a_state, a_imem_req, a_ir_we, a_dmem_req, a_dmem_we, a_alu_src, a_alu_ctrl,
                    a_imm_sel, a_reg_write, a_wb_sel, a_pc_we, a_pc_sel, a_muldiv_start, a_trap, a_trap_cause};
    assign obs_m = {m_state, m_imem_req, m_ir_we, m_dmem_req, m_dmem_we, m_alu_src, m_alu_ctrl,
                    m_imm_sel, m_reg_write, m_wb_sel, m_pc_we, m_pc_sel, m_muldiv_start, m_trap, m_trap_cause};

    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    bit    use_m = 1'b1;
    string cur_name = "init";
    out_t  exp_q[$];
    vec_t  vecs[$];

    task automatic check(input string name, input out_t got, input out_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h exp=%h (state got %0d exp %0d)",
                     name, cyc, got, exp, got.state, exp.state);
        end
    endtask

    function automatic vec_t mkv(input logic [31:0] i, input logic br, input cls_e c,
                                 input logic s, input logic [4:0] ctl, input logic [2:0] im, input string n);
        vec_t v;
        v.instr = i; v.br = br; v.cls = c; v.src = s; v.ctrl = ctl; v.imm = im; v.name = n;
        return v;
    endfunction

    function automatic out_t st(input logic [2:0] s);
        out_t o = '0;
        o.state = s;
        return o;
    endfunction

    function automatic out_t alu(input logic [2:0] s, input vec_t v);
        out_t o = st(s);
        o.alu_src = v.src; o.alu_ctrl = v.ctrl; o.imm_sel = v.imm;
        return o;
    endfunction

    function automatic out_t fetch_exp(input logic ack);
        out_t o = st(3'd0);
        o.imem_req = 1'b1; o.ir_we = ack;
        return o;
    endfunction

    function automatic out_t wb_exp(input vec_t v, input logic [1:0] ws, input logic [1:0] ps);
        out_t o = alu(3'd4, v);
        o.reg_write = 1'b1; o.pc_we = 1'b1; o.wb_sel = ws; o.pc_sel = ps;
        return o;
    endfunction

    function automatic out_t trap_exp(input logic [1:0] cause);
        out_t o = st(3'd6);
        o.trap = 1'b1; o.trap_cause = cause;
        return o;
    endfunction

    function automatic out_t mem_exp(input vec_t v, input logic store, input logic ack);
        out_t o = alu(3'd3, v);
        o.dmem_req = 1'b1; o.dmem_we = store; o.pc_we = store & ack;
        return o;
    endfunction

    // Expected trace for one instruction with every handshake answered at once.
    task automatic push_seq(input vec_t v);
        out_t o;
        exp_q.push_back(fetch_exp(1'b1));
        o = st(3'd1);
        o.muldiv_start = (v.cls == C_MD);
        exp_q.push_back(o);
        case (v.cls)
            C_ILL: begin
                exp_q.push_back(trap_exp(2'd0));
                exp_q.push_back(trap_exp(2'd0));
                return;
            end
            C_BR, C_FENCE: begin
                o = alu(3'd2, v);
                o.pc_we = 1'b1;
                o.pc_sel = (v.cls == C_BR && v.br) ? 2'd1 : 2'd0;
                exp_q.push_back(o);
            end
            C_STORE: begin
                exp_q.push_back(alu(3'd2, v));
                exp_q.push_back(mem_exp(v, 1'b1, 1'b1));
            end
            C_LOAD: begin
                exp_q.push_back(alu(3'd2, v));
                exp_q.push_back(mem_exp(v, 1'b0, 1'b1));
                exp_q.push_back(wb_exp(v, 2'd1, 2'd0));
            end
            C_MD: begin
                exp_q.push_back(alu(3'd5, v));
                exp_q.push_back(wb_exp(v, 2'd3, 2'd0));
            end
            C_JAL: begin
                exp_q.push_back(alu(3'd2, v));
                exp_q.push_back(wb_exp(v, 2'd2, 2'd1));
            end
            C_JALR: begin
                exp_q.push_back(alu(3'd2, v));
                exp_q.push_back(wb_exp(v, 2'd2, 2'd2));
            end
            default: begin
                exp_q.push_back(alu(3'd2, v));
                exp_q.push_back(wb_exp(v, 2'd0, 2'd0));
            end
        endcase
        exp_q.push_back(fetch_exp(1'b1));
    endtask

    task automatic tick(input logic ia, input logic da, input logic md, input logic br);
        out_t got;
        @(posedge clk);
        #1;
        rst = 1'b0; imem_ack = ia; dmem_ack = da; muldiv_done = md; br_taken = br;
        @(negedge clk);
        got = use_m ? obs_m : obs_a;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s cyc=%0d scoreboard empty, got=%h", cur_name, cyc, got);
        end else begin
            check(cur_name, got, exp_q.pop_front());
        end
        cyc++;
    endtask

    task automatic do_reset(input logic da);
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s leftover expected entries got %0d exp 0", cur_name, exp_q.size());
            exp_q.delete();
        end
        @(posedge clk);
        #1;
        rst = 1'b1; imem_ack = 1'b1; dmem_ack = da; muldiv_done = 1'b1;
        @(negedge clk);
        check({cur_name, "_rst_a"}, obs_a, '0);
        check({cur_name, "_rst_m"}, obs_m, '0);
        cyc = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired got running exp finished");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;

        vecs.push_back(mkv(32'h002081B3, 0, C_ALU,   0, 5'd0,  3'd0, "add"));
        vecs.push_back(mkv(32'h402081B3, 0, C_ALU,   0, 5'd1,  3'd0, "sub"));
        vecs.push_back(mkv(32'h4020D1B3, 0, C_ALU,   0, 5'd7,  3'd0, "sra"));
        vecs.push_back(mkv(32'h0050F193, 0, C_ALU,   1, 5'd2,  3'd0, "andi"));
        vecs.push_back(mkv(32'h4030D193, 0, C_ALU,   1, 5'd7,  3'd0, "srai"));
        vecs.push_back(mkv(32'h0050B193, 0, C_ALU,   1, 5'd9,  3'd0, "sltiu"));
        vecs.push_back(mkv(32'h123451B7, 0, C_ALU,   1, 5'd0,  3'd3, "lui"));
        vecs.push_back(mkv(32'h12345197, 0, C_ALU,   1, 5'd0,  3'd3, "auipc"));
        vecs.push_back(mkv(32'h0000A103, 0, C_LOAD,  1, 5'd0,  3'd0, "lw"));
        vecs.push_back(mkv(32'h0020A023, 0, C_STORE, 1, 5'd0,  3'd1, "sw"));
        vecs.push_back(mkv(32'h00208463, 1, C_BR,    0, 5'd1,  3'd2, "beq_taken"));
        vecs.push_back(mkv(32'h00209463, 0, C_BR,    0, 5'd1,  3'd2, "bne_not_taken"));
        vecs.push_back(mkv(32'h0020E463, 1, C_BR,    0, 5'd9,  3'd2, "bltu_taken"));
        vecs.push_back(mkv(32'h010000EF, 0, C_JAL,   1, 5'd0,  3'd4, "jal"));
        vecs.push_back(mkv(32'h000100E7, 0, C_JALR,  1, 5'd0,  3'd0, "jalr"));
        vecs.push_back(mkv(32'h0FF0000F, 0, C_FENCE, 0, 5'd0,  3'd0, "fence"));
        vecs.push_back(mkv(32'h022081B3, 0, C_MD,    0, 5'h10, 3'd0, "mul"));
        vecs.push_back(mkv(32'h0220D1B3, 0, C_MD,    0, 5'h15, 3'd0, "divu"));
        vecs.push_back(mkv(32'h00000073, 0, C_ILL,   0, 5'd0,  3'd0, "ecall"));
        vecs.push_back(mkv(32'h40309193, 0, C_ILL,   0, 5'd0,  3'd0, "slli_bad_f7"));
        vecs.push_back(mkv(32'h0000B103, 0, C_ILL,   0, 5'd0,  3'd0, "load_f3_011"));
        vecs.push_back(mkv(32'h0020A463, 0, C_ILL,   0, 5'd0,  3'd0, "branch_f3_010"));
        vecs.push_back(mkv(32'h000110E7, 0, C_ILL,   0, 5'd0,  3'd0, "jalr_f3_001"));
        vecs.push_back(mkv(32'h402091B3, 0, C_ILL,   0, 5'd0,  3'd0, "rtype_alt_sll"));
        vecs.push_back(mkv(32'h0020B023, 0, C_ILL,   0, 5'd0,  3'd0, "store_f3_011"));
        vecs.push_back(mkv(32'h0000007F, 0, C_ILL,   0, 5'd0,  3'd0, "bad_opcode"));

        // Table: every class with immediate handshakes on the M-enabled instance.
        foreach (vecs[i]) begin
            do_reset(1'b0);
            cur_name = vecs[i].name;
            instr = vecs[i].instr;
            use_m = 1'b1;
            push_seq(vecs[i]);
            while (exp_q.size() > 0) tick(1'b1, 1'b1, 1'b1, vecs[i].br);
        end

        // Load with dmem_ack arriving on the fourth MEM cycle.
        do_reset(1'b0);
        cur_name = "lw_delay";
        use_m = 1'b1;
        v = mkv(32'h0000A103, 0, C_LOAD, 1, 5'd0, 3'd0, "lw_delay");
        instr = v.instr;
        exp_q.push_back(fetch_exp(1'b1));
        exp_q.push_back(st(3'd1));
        exp_q.push_back(alu(3'd2, v));
        for (int k = 0; k < 4; k++) exp_q.push_back(mem_exp(v, 1'b0, 1'b0));
        exp_q.push_back(wb_exp(v, 2'd1, 2'd0));
        exp_q.push_back(fetch_exp(1'b1));
        for (int k = 0; k < 9; k++) tick(1'b1, (k == 6), 1'b0, 1'b0);

        // MUL without the M extension traps and stays trapped.
        do_reset(1'b0);
        cur_name = "mul_no_m";
        use_m = 1'b0;
        instr = 32'h022081B3;
        exp_q.push_back(fetch_exp(1'b1));
        exp_q.push_back(st(3'd1));
        for (int k = 0; k < 20; k++) exp_q.push_back(trap_exp(2'd0));
        for (int k = 0; k < 22; k++) tick(1'b1, 1'b1, 1'b1, 1'b0);

        // MUL with done raised during DECODE (ignored), then late in MULDIV.
        do_reset(1'b0);
        cur_name = "mul_late_done";
        use_m = 1'b1;
        v = mkv(32'h022081B3, 0, C_MD, 0, 5'h10, 3'd0, "mul_late_done");
        instr = v.instr;
        exp_q.push_back(fetch_exp(1'b1));
        begin
            out_t o;
            o = st(3'd1);
            o.muldiv_start = 1'b1;
            exp_q.push_back(o);
        end
        for (int k = 0; k < 3; k++) exp_q.push_back(alu(3'd5, v));
        exp_q.push_back(wb_exp(v, 2'd3, 2'd0));
        exp_q.push_back(fetch_exp(1'b1));
        for (int k = 0; k < 7; k++) tick(1'b1, 1'b0, (k == 1 || k == 4), 1'b0);

        // Fetch timeout with MEM_TIMEOUT=4.
        do_reset(1'b0);
        cur_name = "imem_timeout";
        use_m = 1'b0;
        instr = 32'h002081B3;
        for (int k = 0; k < 4; k++) exp_q.push_back(fetch_exp(1'b0));
        for (int k = 0; k < 3; k++) exp_q.push_back(trap_exp(2'd1));
        for (int k = 0; k < 7; k++) tick(1'b0, 1'b0, 1'b0, 1'b0);

        // Ack on the last allowed fetch cycle wins over the timeout.
        do_reset(1'b0);
        cur_name = "imem_ack_last";
        use_m = 1'b0;
        v = mkv(32'h002081B3, 0, C_ALU, 0, 5'd0, 3'd0, "imem_ack_last");
        instr = v.instr;
        for (int k = 0; k < 3; k++) exp_q.push_back(fetch_exp(1'b0));
        exp_q.push_back(fetch_exp(1'b1));
        exp_q.push_back(st(3'd1));
        exp_q.push_back(alu(3'd2, v));
        exp_q.push_back(wb_exp(v, 2'd0, 2'd0));
        exp_q.push_back(fetch_exp(1'b1));
        for (int k = 0; k < 8; k++) tick((k == 3 || k == 7), 1'b1, 1'b1, 1'b0);

        // Data memory timeout on a store.
        do_reset(1'b0);
        cur_name = "dmem_timeout";
        use_m = 1'b0;
        v = mkv(32'h0020A023, 0, C_STORE, 1, 5'd0, 3'd1, "dmem_timeout");
        instr = v.instr;
        exp_q.push_back(fetch_exp(1'b1));
        exp_q.push_back(st(3'd1));
        exp_q.push_back(alu(3'd2, v));
        for (int k = 0; k < 4; k++) exp_q.push_back(mem_exp(v, 1'b1, 1'b0));
        for (int k = 0; k < 2; k++) exp_q.push_back(trap_exp(2'd2));
        for (int k = 0; k < 9; k++) tick(1'b1, 1'b0, 1'b0, 1'b0);

        // Reset during a store's MEM cycle, with dmem_ack high in the reset cycle.
        do_reset(1'b0);
        cur_name = "rst_in_mem";
        use_m = 1'b1;
        v = mkv(32'h0020A023, 0, C_STORE, 1, 5'd0, 3'd1, "rst_in_mem");
        instr = v.instr;
        exp_q.push_back(fetch_exp(1'b1));
        exp_q.push_back(st(3'd1));
        exp_q.push_back(alu(3'd2, v));
        exp_q.push_back(mem_exp(v, 1'b1, 1'b0));
        for (int k = 0; k < 4; k++) tick(1'b1, 1'b0, 1'b0, 1'b0);
        do_reset(1'b1);
        cur_name = "after_rst";
        push_seq(v);
        while (exp_q.size() > 0) tick(1'b1, 1'b1, 1'b1, 1'b0);

        do_reset(1'b0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
